// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver: shared constants.
// State encoding and default sizing for the frame receiver and FIFO.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int TIMEOUT_DEF    = 50000;
  localparam int DEPTH_LOG2_DEF = 3;

endpackage

// File: rtl/ps2_fifo.sv
// PS/2 receive FIFO: show-ahead byte queue.
// Full-with-pop accepts the push; pop on empty is ignored.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the raw lines, frames
// 11-bit packets and queues good bytes for the CPU.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  input  logic                rd,
  input  logic                clr,
  output logic [7:0]          dout,
  output logic                valid,
  output logic [DEPTH_LOG2:0] count,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          sample;
  logic          dat;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          par_ok;
  logic          push_r;
  logic [TW-1:0] idle_cnt;
  logic          timeout;
  logic          pe_set;
  logic          fe_set;
  logic          ov_set;
  logic          full;
  logic          empty;

  // Lines idle high, so the synchronizers reset to 1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign sample  = clk_prev & ~clk_sync[1];
  assign dat     = dat_sync[1];
  assign par_ok  = ^{shreg, par_bit};
  assign timeout = (state != ST_IDLE) & ~sample &
                   (idle_cnt == TW'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if (state == ST_IDLE || sample || timeout)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      push_r  <= 1'b0;
    end else begin
      push_r <= 1'b0;
      if (timeout) begin
        state <= ST_IDLE;
      end else if (sample) begin
        unique case (state)
          ST_IDLE: begin
            if (!dat) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state  <= ST_IDLE;
            push_r <= dat & par_ok;
          end
        endcase
      end
    end
  end

  assign pe_set = sample & (state == ST_STOP) & ~par_ok;
  assign fe_set = sample & (state == ST_STOP) & ~dat;
  assign ov_set = push_r & full & ~rd;

  // A flag event coinciding with clr keeps the flag set.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= pe_set | (parity_err & ~clr);
      frame_err  <= fe_set | (frame_err & ~clr);
      overflow   <= ov_set | (overflow & ~clr);
    end
  end

  ps2_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_r),
    .pop     (rd),
    .din     (shreg),
    .dout    (dout),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign valid = ~empty;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed PS/2 frames checked against
// a queue-based model every cycle plus literal expectations.
module tb_ps2_keyboard;

  localparam int H = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       rd;
  logic       clr;
  logic [7:0] dout;
  logic       valid;
  logic [3:0] count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic [7:0] mq[$];
  logic m_pe = 1'b0;
  logic m_fe = 1'b0;
  logic m_ov = 1'b0;

  ps2_keyboard dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rd         (rd),
    .clr        (clr),
    .dout       (dout),
    .valid      (valid),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_valid", valid, mq.size() != 0);
      chk("m_count", count, mq.size());
      chk("m_dout", dout, mq.size() != 0 ? mq[0] : 8'h00);
      chk("m_perr", parity_err, m_pe);
      chk("m_ferr", frame_err, m_fe);
      chk("m_ovf", overflow, m_ov);
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Drives nbits of the frame; on a full frame, optional rd/clr
  // pulses land on the stop-sample and push clocks.
  task automatic send(input logic [7:0] d, input logic par,
                      input logic stp, input int nbits,
                      input logic rd_hit, input logic clr_hit);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      repeat (H) @(negedge clock);
      if (i == 10) chk_en = 1'b0;
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (2) @(negedge clock);
        if (clr_hit) clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        if (rd_hit) rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
        repeat (H - 4) @(negedge clock);
      end else begin
        repeat (H) @(negedge clock);
      end
      ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clock);
  endtask

  task automatic frame(input logic [7:0] d, input logic par,
                       input logic stp, input logic rd_hit,
                       input logic clr_hit);
    send(d, par, stp, 11, rd_hit, clr_hit);
    if (clr_hit) begin
      m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    end
    if (rd_hit && mq.size() != 0) void'(mq.pop_front());
    if (!stp) m_fe = 1'b1;
    if ((^{d, par}) == 1'b0) m_pe = 1'b1;
    if (stp && (^{d, par}) == 1'b1) begin
      if (mq.size() == 8) m_ov = 1'b1;
      else mq.push_back(d);
    end
    chk_en = 1'b1;
  endtask

  task automatic good(input logic [7:0] d);
    frame(d, odd_par(d), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop();
    chk_en = 1'b0;
    rd = 1'b1;
    if (mq.size() != 0) void'(mq.pop_front());
    @(negedge clock);
    rd = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic clear();
    chk_en = 1'b0;
    clr = 1'b1;
    m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    @(negedge clock);
    clr = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rd      = 1'b0;
    clr     = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_flags", {parity_err, frame_err, overflow}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;

    good(8'h1C);
    chk("b1c_dout", dout, 8'h1C);
    chk("b1c_count", count, 1);
    chk("b1c_flags", {parity_err, frame_err, overflow}, 0);
    pop();
    chk("b1c_empty", valid, 0);
    pop();
    chk("under_count", count, 0);

    frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_err", parity_err, 1);
    chk("par_novalid", valid, 0);
    clear();
    chk("par_clr", parity_err, 0);

    frame(8'h33, odd_par(8'h33), 1'b0, 1'b0, 1'b0);
    chk("frm_err", frame_err, 1);
    chk("frm_novalid", valid, 0);
    clear();

    frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_vs_set", parity_err, 1);
    clear();

    for (int i = 1; i <= 9; i++) good(8'(i));
    chk("ovf_count", count, 8);
    chk("ovf_dout", dout, 8'h01);
    chk("ovf_flag", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_pop", dout, i);
      pop();
    end
    chk("ovf_drained", valid, 0);
    clear();

    send(8'h05, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    repeat (50000 + H) @(negedge clock);
    good(8'hF0);
    chk("to_dout", dout, 8'hF0);
    chk("to_count", count, 1);
    chk("to_flags", {parity_err, frame_err, overflow}, 0);
    pop();

    for (int i = 0; i < 8; i++) good(8'h40 + 8'(i));
    chk("full_count", count, 8);
    frame(8'h55, odd_par(8'h55), 1'b1, 1'b1, 1'b0);
    chk("pp_count", count, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", dout, 8'h41);
    for (int i = 1; i < 8; i++) begin
      chk("pp_pop", dout, 8'h40 + 8'(i));
      pop();
    end
    chk("pp_last", dout, 8'h55);
    pop();
    chk("pp_empty", valid, 0);

    send(8'hAA, odd_par(8'hAA), 1'b1, 5, 1'b0, 1'b0);
    chk_en = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    mq.delete();
    m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    good(8'h12);
    chk("rstf_dout", dout, 8'h12);
    chk("rstf_count", count, 1);
    chk("rstf_flags", {parity_err, frame_err, overflow}, 0);
    pop();
    chk("rstf_empty", valid, 0);

    repeat (4) @(negedge clock);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
